// File: rtl/gf_inverse_if.sv
// Byte stream handshake bundle for the GF(2^8) inverse unit.
// Input side carries the byte to invert, output side the inverse.
interface gf_inverse_if;
   logic [7:0] idata;
   logic       ivalid;
   logic       iready;
   logic [7:0] odata;
   logic       ovalid;
   logic       oready;

   modport master (
      output idata,
      output ivalid,
      input  iready,
      input  odata,
      input  ovalid,
      output oready
   );

   modport slave (
      input  idata,
      input  ivalid,
      output iready,
      output odata,
      output ovalid,
      input  oready
   );
endinterface

// File: rtl/gf_inverse.sv
// Iterative AES-field inverse: x^254 via one square and one multiply
// per cycle, feeding the forward S-box affine stage.
module gf_inverse #(
   parameter logic [7:0] POLY = 8'h1B
) (
   input logic         clk,
   input logic         rst,
   gf_inverse_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] sq_q, sq_d;
   logic [7:0] acc_q, acc_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] odata_q, odata_d;
   logic [7:0] s2;
   logic [7:0] prod;

   function automatic logic [7:0] gf_mul(
      input logic [7:0] a,
      input logic [7:0] b
   );
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? POLY : 8'h00);
      end
      return p;
   endfunction

   assign s2   = gf_mul(sq_q, sq_q);
   assign prod = gf_mul(acc_q, s2);

   // rst gates iready so nothing is offered while held in reset
   assign bus.iready = (state_q == IDLE) && rst;
   assign bus.ovalid = (state_q == DONE);
   assign bus.odata  = odata_q;

   always_comb begin
      state_d = state_q;
      sq_d    = sq_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      odata_d = odata_q;
      unique case (state_q)
         IDLE: begin
            if (bus.ivalid) begin
               sq_d    = bus.idata;
               acc_d   = 8'h01;
               cnt_d   = 3'd0;
               state_d = CALC;
            end
         end
         CALC: begin
            sq_d  = s2;
            acc_d = prod;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd6) begin
               odata_d = prod;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.oready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         sq_q    <= 8'h00;
         acc_q   <= 8'h00;
         cnt_q   <= 3'd0;
         odata_q <= 8'h00;
      end else begin
         state_q <= state_d;
         sq_q    <= sq_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         odata_q <= odata_d;
      end
   end

endmodule
